// File: rtl/mac_seq_ctrl.sv
// Purpose: job sequencer for the 4-lane MAC array plus result-RAM arbiter (write-back vs host).
// Latency: busy/op_rd rise the cycle after start is sampled; per group K_LEN+MAC_LAT+6 cycles.
// Backpressure: none on the job path; host_req stalls (host_gnt=0) outside IDLE or while start is high.
module mac_seq_ctrl #(
  parameter int K_LEN   = 8,
  parameter int N_GRP   = 4,
  parameter int MAC_LAT = 2,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              op_rd,
  output logic [ADDR_W-1:0] op_addr,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              web,
  input  logic              host_req,
  output logic              host_gnt,
  output logic              ram_sel
);

  localparam int K_W     = (K_LEN > 1) ? $clog2(K_LEN) : 1;
  localparam int G_W     = (N_GRP > 1) ? $clog2(N_GRP) : 1;
  localparam int CNT_MAX = (MAC_LAT > 3) ? MAC_LAT : 3;
  localparam int C_W     = $clog2(CNT_MAX + 1);

  localparam logic [K_W-1:0] K_LAST     = K_W'(K_LEN - 1);
  localparam logic [G_W-1:0] G_LAST     = G_W'(N_GRP - 1);
  localparam logic [C_W-1:0] DRAIN_LAST = C_W'(MAC_LAT);
  localparam logic [C_W-1:0] HOLD_LAST  = C_W'(3);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    WBTRIG,
    WBHOLD,
    DONE
  } state_t;

  state_t         state;
  logic [G_W-1:0] grp;
  logic [K_W-1:0] k;
  logic [C_W-1:0] cnt;

  // Host may own the result RAM only while idle and not being asked to start a job.
  assign host_gnt = rst & host_req & (state == IDLE) & ~start;
  assign ram_sel  = host_gnt;

  // Sequencer FSM; every output is registered alongside the state it belongs to.
  // op_addr is stepped by one, which reproduces grp*K_LEN+k across group boundaries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      grp     <= '0;
      k       <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      op_rd   <= 1'b0;
      op_addr <= '0;
      mac_clr <= 1'b0;
      mac_en  <= 1'b0;
      web     <= 1'b0;
    end else begin
      // MAC controls trail the operand read by the RAM's one-cycle latency.
      mac_en  <= op_rd;
      mac_clr <= op_rd & (k == '0);
      web     <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= FETCH;
            grp     <= '0;
            k       <= '0;
            busy    <= 1'b1;
            op_rd   <= 1'b1;
            op_addr <= '0;
          end
        end
        FETCH: begin
          if (k == K_LAST) begin
            state <= DRAIN;
            k     <= '0;
            cnt   <= '0;
            op_rd <= 1'b0;
          end else begin
            k       <= k + 1'b1;
            op_addr <= op_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          // MAC_LAT+1 cycles: the last mac_en plus the pipeline depth.
          if (cnt == DRAIN_LAST) begin
            state <= WBTRIG;
            cnt   <= '0;
            web   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WBTRIG: begin
          state <= WBHOLD;
          cnt   <= '0;
        end
        WBHOLD: begin
          // Write-back owns the RAM for four cycles to store the group's four words.
          if (cnt == HOLD_LAST) begin
            cnt <= '0;
            if (grp == G_LAST) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= FETCH;
              grp     <= grp + 1'b1;
              op_rd   <= 1'b1;
              op_addr <= op_addr + ADDR_W'(1);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          op_rd <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
module tb_mac_seq_ctrl;

  localparam int TK = 8;
  localparam int TM = 2;
  localparam int TN = 4;
  localparam int TL = TK + TM + 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       host_req = 1'b0;
  logic       busy, done, op_rd, mac_clr, mac_en, web, host_gnt, ram_sel;
  logic [7:0] op_addr;

  logic       s_start = 1'b0;
  logic       s_host_req = 1'b0;
  logic       s_busy, s_done, s_op_rd, s_mac_clr, s_mac_en, s_web, s_host_gnt, s_ram_sel;
  logic [7:0] s_op_addr;

  int errors = 0;
  int checks = 0;

  int addr_q[$];
  int web_q[$];
  int done_q[$];

  always #5 clk = ~clk;

  mac_seq_ctrl #(.K_LEN(TK), .N_GRP(TN), .MAC_LAT(TM), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .op_rd(op_rd), .op_addr(op_addr), .mac_clr(mac_clr), .mac_en(mac_en),
    .web(web), .host_req(host_req), .host_gnt(host_gnt), .ram_sel(ram_sel)
  );

  mac_seq_ctrl #(.K_LEN(1), .N_GRP(1), .MAC_LAT(1), .ADDR_W(8)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
    .op_rd(s_op_rd), .op_addr(s_op_addr), .mac_clr(s_mac_clr), .mac_en(s_mac_en),
    .web(s_web), .host_req(s_host_req), .host_gnt(s_host_gnt), .ram_sel(s_ram_sel)
  );

  // Reset state of both instances, with host_req high to show the grant is held off too.
  task automatic test_reset();
    logic [7:0] outs;
    rst = 1'b0;
    host_req = 1'b1;
    s_host_req = 1'b1;
    repeat (2) @(negedge clk);
    outs = {busy, done, op_rd, mac_clr, mac_en, web, host_gnt, ram_sel};
    checks++;
    if (outs !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000000", outs);
    end
    checks++;
    if (op_addr !== 8'd0) begin
      errors++;
      $display("FAIL reset_addr: got %0d want 0", op_addr);
    end
    outs = {s_busy, s_done, s_op_rd, s_mac_clr, s_mac_en, s_web, s_host_gnt, s_ram_sel};
    checks++;
    if (outs !== 8'h00) begin
      errors++;
      $display("FAIL reset_small: got %b want 00000000", outs);
    end
    host_req = 1'b0;
    s_host_req = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // One full default job, checked cycle by cycle against a cycle-arithmetic model.
  // host_from: cycle from which host_req is held (-1 = never); restart_at: extra start pulse.
  task automatic run_job(input string tag, input int host_from, input int restart_at);
    int  last_c;
    int  g, o;
    bit  exp_rd, exp_busy, exp_gnt;
    bit  prev_rd, prev_first;
    int  got_addr;
    last_c = TN * TL + 3;
    addr_q.delete();
    web_q.delete();
    done_q.delete();
    for (int gg = 0; gg < TN; gg++) begin
      for (int kk = 0; kk < TK; kk++) addr_q.push_back(gg * TK + kk);
      web_q.push_back(gg * TL + TK + TM + 2);
    end
    done_q.push_back(TN * TL + 1);

    // Cycle 0: start is sampled at the closing edge.
    start = 1'b1;
    host_req = (host_from == 0);
    #1;
    checks++;
    if (host_gnt !== 1'b0 || ram_sel !== 1'b0) begin
      errors++;
      $display("FAIL %s gnt_c0: got gnt=%b sel=%b want 0 0", tag, host_gnt, ram_sel);
    end
    prev_rd = 1'b0;
    prev_first = 1'b0;

    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      g = (c - 1) / TL;
      o = (c - 1) % TL;
      exp_rd   = (c >= 1) && (c <= TN * TL) && (o < TK);
      exp_busy = (c >= 1) && (c <= TN * TL + 1);
      exp_gnt  = host_req && (c >= TN * TL + 2) && !start;

      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL %s busy c%0d: got %b want %b", tag, c, busy, exp_busy);
      end
      checks++;
      if (op_rd !== exp_rd) begin
        errors++;
        $display("FAIL %s op_rd c%0d: got %b want %b", tag, c, op_rd, exp_rd);
      end
      checks++;
      if (mac_en !== prev_rd || mac_clr !== prev_first) begin
        errors++;
        $display("FAIL %s mac c%0d: got en=%b clr=%b want %b %b", tag, c, mac_en, mac_clr,
                 prev_rd, prev_first);
      end
      if (op_rd === 1'b1) begin
        checks++;
        if (addr_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_op_rd c%0d: got addr %0d want none", tag, c, op_addr);
        end else begin
          got_addr = addr_q.pop_front();
          if (int'(op_addr) !== got_addr) begin
            errors++;
            $display("FAIL %s op_addr c%0d: got %0d want %0d", tag, c, op_addr, got_addr);
          end
        end
      end
      if (web === 1'b1) begin
        checks++;
        if (web_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_web: got cycle %0d want none", tag, c);
        end else if (web_q[0] != c) begin
          errors++;
          $display("FAIL %s web_cycle: got %0d want %0d", tag, c, web_q.pop_front());
        end else begin
          void'(web_q.pop_front());
        end
      end
      if (done === 1'b1) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_done: got cycle %0d want none", tag, c);
        end else if (done_q[0] != c) begin
          errors++;
          $display("FAIL %s done_cycle: got %0d want %0d", tag, c, done_q.pop_front());
        end else begin
          void'(done_q.pop_front());
        end
      end
      checks++;
      if (host_gnt !== exp_gnt || ram_sel !== exp_gnt) begin
        errors++;
        $display("FAIL %s gnt c%0d: got gnt=%b sel=%b want %b", tag, c, host_gnt, ram_sel,
                 exp_gnt);
      end

      prev_rd = exp_rd;
      prev_first = exp_rd && (o == 0);
      if (g < 0) prev_first = 1'b0;
      start = (c == restart_at);
      host_req = (host_from >= 0) && (c >= host_from);
    end

    checks++;
    if (addr_q.size() != 0 || web_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL %s leftover: got addr=%0d web=%0d done=%0d want 0 0 0", tag,
               addr_q.size(), web_q.size(), done_q.size());
    end
    start = 1'b0;
    host_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_job();
    run_job("basic", -1, -1);
  endtask

  task automatic test_host_stall();
    run_job("host_stall", 5, -1);
  endtask

  task automatic test_start_collision();
    run_job("collide", 0, 20);
  endtask

  // Reset in the third group's FETCH, then a fresh job must behave exactly like the first.
  task automatic test_reset_mid_job();
    logic [7:0] outs;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 2; c <= 35; c++) @(negedge clk);
    checks++;
    if (op_rd !== 1'b1 || op_addr !== 8'd18) begin
      errors++;
      $display("FAIL midrst_pre: got rd=%b addr=%0d want 1 18", op_rd, op_addr);
    end
    rst = 1'b0;
    #1;
    outs = {busy, done, op_rd, mac_clr, mac_en, web, host_gnt, ram_sel};
    checks++;
    if (outs !== 8'h00 || op_addr !== 8'd0) begin
      errors++;
      $display("FAIL midrst_async: got %b addr=%0d want 00000000 0", outs, op_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || op_rd !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle: got busy=%b rd=%b want 0 0", busy, op_rd);
    end
    run_job("after_rst", -1, -1);
  endtask

  // Minimal configuration: K_LEN=1, N_GRP=1, MAC_LAT=1.
  task automatic test_small_cfg();
    logic [5:0] got, want;
    s_start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      s_start = 1'b0;
      got  = {s_busy, s_op_rd, s_mac_en, s_mac_clr, s_web, s_done};
      want = {(c >= 1 && c <= 9), (c == 1), (c == 2), (c == 2), (c == 4), (c == 9)};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL small c%0d: got busy/rd/en/clr/web/done=%b want %b", c, got, want);
      end
      if (c == 1) begin
        checks++;
        if (s_op_addr !== 8'd0) begin
          errors++;
          $display("FAIL small_addr: got %0d want 0", s_op_addr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_job();
    test_host_stall();
    test_start_collision();
    test_reset_mid_job();
    test_small_cfg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
